// File: rtl/pb_interrupt_controller.sv
// Multi-source interrupt controller for pacoblaze3: an internal tick timer plus
// external edge-triggered lines, merged onto one fixed-priority interrupt/ack pair.
module pb_interrupt_controller #(
  parameter int          NUM_SRC   = 4,
  parameter int          TICK_DIV  = 250000,
  parameter logic [7:0]  BASE_PORT = 8'h08
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-2:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         rd_data,
  output logic               interrupt,
  input  logic               interrupt_ack,
  output logic               tick,
  output logic [1:0]         fsm_state
);

  localparam int         CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [7:0] A_MASK   = BASE_PORT;
  localparam logic [7:0] A_PEND   = BASE_PORT + 8'd1;
  localparam logic [7:0] A_ACTIVE = BASE_PORT + 8'd2;
  localparam logic [7:0] A_EOI    = BASE_PORT + 8'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [NUM_SRC-2:0] irq_q;
  logic [NUM_SRC-2:0] irq_h;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [7:0]         active_id;

  logic               tick_now;
  logic               wr_mask, wr_pend, wr_eoi, ack_take;
  logic [NUM_SRC-1:0] masked, set_vec, clr_vec, win_onehot;
  logic [2:0]         win_idx;
  logic               win_found;
  logic               req;
  logic [7:0]         rd_next;
  logic               unused_inputs;

  // read_strobe is informational only: reads have no side effects.
  assign unused_inputs = ^{read_strobe, out_port};

  assign fsm_state = state;
  assign tick_now  = (cnt == CNT_MAX);
  assign wr_mask   = write_strobe && (port_id == A_MASK);
  assign wr_pend   = write_strobe && (port_id == A_PEND);
  assign wr_eoi    = write_strobe && (port_id == A_EOI);
  assign masked    = pending & mask;
  assign req       = |masked;
  assign ack_take  = (state == ST_ASSERT) && interrupt_ack;

  // Lowest index wins; scanning downward leaves the lowest set bit last.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = 3'd0;
    win_onehot = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        win_found     = 1'b1;
        win_idx       = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    set_vec = {irq_q & ~irq_h, tick_now};
    clr_vec = '0;
    if (wr_pend)  clr_vec = out_port[NUM_SRC-1:0];
    if (ack_take) clr_vec = clr_vec | win_onehot;
  end

  always_comb begin
    rd_next = 8'h00;
    case (port_id)
      A_MASK:   rd_next = 8'(mask);
      A_PEND:   rd_next = 8'(pending);
      A_ACTIVE: rd_next = active_id;
      default:  rd_next = 8'h00;
    endcase
  end

  // Sets are OR-ed in after clears so a same-cycle set always survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      tick    <= 1'b0;
      irq_q   <= '0;
      irq_h   <= '0;
      pending <= '0;
      mask    <= '0;
      rd_data <= 8'h00;
    end else begin
      cnt     <= tick_now ? '0 : cnt + CW'(1);
      tick    <= tick_now;
      irq_q   <= irq_src;
      irq_h   <= irq_q;
      pending <= (pending & ~clr_vec) | set_vec;
      if (wr_mask) mask <= out_port[NUM_SRC-1:0];
      rd_data <= rd_next;
    end
  end

  // interrupt rises in IDLE when any enabled source is pending and stays high
  // until the core pulses interrupt_ack; the ack is ignored in any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      active_id <= 8'hFF;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            interrupt <= 1'b1;
            state     <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (interrupt_ack) begin
            interrupt <= 1'b0;
            active_id <= win_found ? {5'b00000, win_idx} : 8'hFF;
            state     <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          interrupt <= 1'b0;
          if (wr_eoi) begin
            active_id <= 8'hFF;
            state     <= ST_IDLE;
          end
        end
        default: begin
          interrupt <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_interrupt_controller.sv
// Self-checking bench for pb_interrupt_controller with a short tick period,
// register reads scored through an expected-value queue.
module tb_pb_interrupt_controller;

  localparam int         NUM_SRC  = 4;
  localparam int         TICK_DIV = 10;
  localparam logic [7:0] A_MASK   = 8'h08;
  localparam logic [7:0] A_PEND   = 8'h09;
  localparam logic [7:0] A_ACTIVE = 8'h0A;
  localparam logic [7:0] A_EOI    = 8'h0B;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-2:0] irq_src;
  logic [7:0]         port_id, out_port;
  logic               write_strobe, read_strobe, interrupt_ack;
  logic [7:0]         rd_data;
  logic               interrupt, tick;
  logic [1:0]         fsm_state;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  pb_interrupt_controller #(
    .NUM_SRC(NUM_SRC), .TICK_DIV(TICK_DIV), .BASE_PORT(8'h08)
  ) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .port_id(port_id),
    .out_port(out_port), .write_strobe(write_strobe), .read_strobe(read_strobe),
    .rd_data(rd_data), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .tick(tick), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent tick model: pulses on every TICK_DIV-th edge after reset release.
  always @(posedge clk) begin
    #1;
    if (reset) cyc = 0;
    else begin
      cyc++;
      check("tick", {7'd0, tick}, (cyc % TICK_DIV == 0) ? 8'd1 : 8'd0);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr,
                    input logic [7:0] exp, input logic [7:0] msk);
    logic [7:0] e;
    port_id     = addr;
    read_strobe = 1'b1;
    exp_q.push_back(exp);
    step();
    read_strobe = 1'b0;
    e = exp_q.pop_front();
    check(tag, rd_data & msk, e);
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (interrupt !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, {7'd0, interrupt}, 8'd1);
  endtask

  initial begin
    int k;
    reset = 1'b1; irq_src = '0; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_interrupt", {7'd0, interrupt}, 8'd0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_state", {6'd0, fsm_state}, {6'd0, S_IDLE});
    @(negedge clk);
    reset = 1'b0;

    // 1: tick source
    wr(A_MASK, 8'h01);
    k = 1;
    while (tick !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    check("t1_first_tick_cycle", 8'(k), 8'(TICK_DIV));
    step();
    check("t1_irq_after_tick", {7'd0, interrupt}, 8'd1);
    ack();
    check("t1_irq_after_ack", {7'd0, interrupt}, 8'd0);
    rd("t1_active", A_ACTIVE, 8'h00, 8'hFF);
    wr(A_EOI, 8'h5A);
    rd("t1_active_eoi", A_ACTIVE, 8'hFF, 8'hFF);
    wr(A_MASK, 8'h00);

    // 2: two simultaneous sources, priority
    wr(A_MASK, 8'h0E);
    rd("t2_mask", A_MASK, 8'h0E, 8'hFF);
    irq_src = 3'b101;
    wait_irq("t2_irq1", 4);
    ack();
    rd("t2_active1", A_ACTIVE, 8'h01, 8'hFF);
    check("t2_irq_in_service", {7'd0, interrupt}, 8'd0);
    wr(A_EOI, 8'h00);
    step();
    check("t2_reassert", {7'd0, interrupt}, 8'd1);
    ack();
    rd("t2_active2", A_ACTIVE, 8'h03, 8'hFF);
    wr(A_EOI, 8'h00);
    rd("t2_pending", A_PEND, 8'h00, 8'hFE);
    irq_src = '0;

    // 3: masked source then unmask
    wr(A_MASK, 8'h00);
    irq_src = 3'b010;
    repeat (3) step();
    rd("t3_pending", A_PEND, 8'h04, 8'hFE);
    check("t3_irq_masked", {7'd0, interrupt}, 8'd0);
    wr(A_MASK, 8'h04);
    wait_irq("t3_irq_unmask", 2);
    ack();
    rd("t3_active", A_ACTIVE, 8'h02, 8'hFF);
    wr(A_EOI, 8'h00);
    irq_src = '0;

    // 4: spurious after W1C in ASSERT
    wr(A_MASK, 8'h02);
    irq_src = 3'b001;
    wait_irq("t4_irq", 4);
    wr(A_PEND, 8'h02);
    check("t4_irq_held", {7'd0, interrupt}, 8'd1);
    ack();
    rd("t4_active_spur", A_ACTIVE, 8'hFF, 8'hFF);
    check("t4_state_service", {6'd0, fsm_state}, {6'd0, S_SERVICE});
    wr(A_EOI, 8'h00);
    step();
    check("t4_state_idle", {6'd0, fsm_state}, {6'd0, S_IDLE});
    check("t4_irq_idle", {7'd0, interrupt}, 8'd0);
    irq_src = '0;

    // 5: held level, and set/clear collision
    wr(A_MASK, 8'h00);
    wr(A_PEND, 8'h0E);
    irq_src = 3'b010;
    repeat (100) step();
    rd("t5_one_edge", A_PEND, 8'h04, 8'hFE);
    wr(A_PEND, 8'h04);
    rd("t5_cleared", A_PEND, 8'h00, 8'hFE);
    irq_src = '0;
    repeat (2) step();
    irq_src = 3'b010;
    step();
    wr(A_PEND, 8'h04);
    rd("t5_set_wins", A_PEND, 8'h04, 8'hFE);
    wr(A_EOI, 8'h00);
    check("t5_eoi_idle", {6'd0, fsm_state}, {6'd0, S_IDLE});

    // 6: reset during SERVICE
    irq_src = '0;
    repeat (2) step();
    wr(A_MASK, 8'h04);
    wait_irq("t6_irq", 4);
    ack();
    rd("t6_active", A_ACTIVE, 8'h02, 8'hFF);
    irq_src = 3'b011;
    repeat (3) step();
    rd("t6_pending", A_PEND, 8'h06, 8'hFE);
    check("t6_in_service", {6'd0, fsm_state}, {6'd0, S_SERVICE});
    @(negedge clk);
    reset   = 1'b1;
    irq_src = '0;
    #1;
    check("t6_rst_irq", {7'd0, interrupt}, 8'd0);
    check("t6_rst_tick", {7'd0, tick}, 8'd0);
    check("t6_rst_rd_data", rd_data, 8'h00);
    check("t6_rst_state", {6'd0, fsm_state}, {6'd0, S_IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd("t6_pend_after", A_PEND, 8'h00, 8'hFF);
    rd("t6_mask_after", A_MASK, 8'h00, 8'hFF);
    rd("t6_active_after", A_ACTIVE, 8'hFF, 8'hFF);
    wr(A_MASK, 8'hFF);
    rd("t6_mask_width", A_MASK, 8'h0F, 8'hFF);
    wr(A_MASK, 8'h00);
    check("t6_no_irq", {7'd0, interrupt}, 8'd0);
    irq_src = 3'b100;
    repeat (3) step();
    check("t6_no_irq_masked", {7'd0, interrupt}, 8'd0);
    wr(A_MASK, 8'h08);
    wait_irq("t6_irq_new", 2);
    ack();
    rd("t6_active_new", A_ACTIVE, 8'h03, 8'hFF);
    wr(A_EOI, 8'h00);
    rd("t6_eoi_read", A_EOI, 8'h00, 8'hFF);
    rd("t6_unmapped", 8'h20, 8'h00, 8'hFF);
    irq_src = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pb_interrupt_controller.md
Name: pb_interrupt_controller

Overview:
Multi-source interrupt controller for the pacoblaze3 core. It merges a built-in programmable tick timer and up to NUM_SRC-1 external request lines into the core's single interrupt/interrupt_ack pair. Arbitration is fixed priority, with per-source mask and pending registers. The CPU accesses the block through the core's port_id/out_port/in_port I/O bus and sits beside the existing I/O port decode.

Parameters:
NUM_SRC, 4, total sources including the internal tick (source 0); range 2..8
TICK_DIV, 250000, tick period in clk cycles; source 0 pulses once per period
BASE_PORT, 8'h08, base I/O address; registers occupy BASE_PORT+0..+3

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
irq_src  input  NUM_SRC-1  external request levels; bit i maps to source i+1; rising edge sets pending
port_id  input  8  core port address
out_port  input  8  core write data
write_strobe  input  1  core write qualifier
read_strobe  input  1  core read qualifier (informational; reads are side-effect free)
rd_data  output  8  registered read data, to the system in_port mux
interrupt  output  1  to core interrupt input
interrupt_ack  input  1  from core; one-cycle pulse
tick  output  1  one-cycle tick pulse, also usable elsewhere

Behaviour:
- Reset (async): pending=0, mask=0 (all disabled), active_id=8'hFF, tick counter=0, tick=0, interrupt=0, rd_data=0, edge-detect history=0, FSM=IDLE.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle at wrap. Tick sets pending[0].
- Edge detect: irq_src is registered once, and pending[i] is set on a 0->1 transition of the registered value. The first edge is therefore flagged 2 cycles after the input rises. A level held high produces one edge only.
- Register map (write when write_strobe && port_id==addr):
  - +0 MASK: R/W; bit i=1 enables source i. Bits >= NUM_SRC read 0.
  - +1 PENDING: read gives raw pending (masked and unmasked). Writing 1 clears the bit (W1C).
  - +2 ACTIVE: read-only; index of the source being serviced, or 8'hFF for none/spurious.
  - +3 EOI: write any value to end service. Reads return 0.
- Reads: rd_data <= register selected by port_id, one cycle latency, every cycle. Unmapped addresses return 8'h00.
- Request condition: req = |(pending & mask).
- FSM:
  - IDLE: if req, interrupt<=1 and go to ASSERT.
  - ASSERT: interrupt stays 1 until interrupt_ack. On ack: interrupt<=0; active_id <= lowest-index set bit of (pending & mask), or 8'hFF if none (mask or W1C changed meanwhile); that pending bit is cleared; go to SERVICE.
  - SERVICE: interrupt held 0 regardless of req. An EOI write sets active_id<=8'hFF and goes to IDLE. A pending req is re-asserted on the cycle after return to IDLE.
- interrupt_ack outside ASSERT is ignored.
- Simultaneous events:
  - A set (edge/tick) and a clear (W1C or ack) on the same bit in the same cycle: set wins, and the bit stays pending.
  - A MASK write in the same cycle as ack: the arbitration uses the old mask.
  - An EOI write in IDLE or ASSERT: no effect.
- interrupt is a registered output, with no combinational path from any input.
- Mid-operation reset returns every state above to its reset value immediately. Edges occurring during reset are lost.

Test Plan:
1. Reset, then MASK=8'h01 with TICK_DIV=10 → tick pulses at cycles 10, 20, ...; interrupt rises 1 cycle after the first tick; ack pulse → interrupt=0 and ACTIVE reads 8'h00; EOI write → ACTIVE=8'hFF.
2. MASK=8'h0E; irq_src[0] and irq_src[2] (sources 1 and 3) rise in the same cycle → ack gives ACTIVE=1; after EOI, interrupt re-asserts; second ack gives ACTIVE=3; PENDING reads 0 afterwards.
3. MASK=8'h00; irq_src[1] rises → PENDING=8'h04 and interrupt stays 0; MASK=8'h04 → interrupt=1 within 2 cycles.
4. In ASSERT, clear the only pending bit via PENDING W1C 8'h02, then ack → ACTIVE=8'hFF (spurious) and FSM in SERVICE; EOI → IDLE with interrupt=0.
5. Hold the source 2 line high for 100 cycles → exactly one pending set. Same cycle as the W1C of bit 2, raise source 2 again after a low → bit 2 remains pending.
6. Assert reset while in SERVICE with PENDING=8'h06 → all outputs zero/8'hFF immediately; after release, no interrupt until a new edge occurs and MASK is rewritten.
